// File: rtl/stack_unit_pkg.sv
// Shared definitions for the MiniRISC call/interrupt stack: FSM states,
// operation select encodings and flag bit positions.
package stack_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  localparam int unsigned FLAGS_W = 6;
  localparam int unsigned FLG_IE  = 5;
  localparam int unsigned FLG_IF  = 4;
  localparam int unsigned FLG_Z   = 3;
  localparam int unsigned FLG_C   = 2;
  localparam int unsigned FLG_N   = 1;
  localparam int unsigned FLG_V   = 0;

endpackage

// File: rtl/stack_ram.sv
// Single-port stack storage: synchronous write, registered synchronous read.
module stack_ram #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 14
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/stack_unit.sv
// Hardware call/interrupt stack: saves {flags, pc} on push, returns them on pop,
// serialised by an IDLE -> ACCESS -> DONE handshake with the control unit.
module stack_unit
  import stack_unit_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned PC_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stack_op_ongoing,
  input  logic                 push_or_pop,
  input  logic [PC_W-1:0]      pc,
  input  logic [5:0]           flags_din,
  output logic [PC_W-1:0]      return_addr,
  output logic [5:0]           flags_dout,
  output logic                 stack_op_end,
  output logic [DEPTH_LOG2:0]  sp,
  output logic                 stack_full,
  output logic                 stack_empty,
  output logic                 stack_ovf,
  output logic                 stack_unf
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned DATA_W = PC_W + FLAGS_W;

  state_t state_q, state_d;

  logic                  op_q;
  logic [PC_W-1:0]       pc_q;
  logic [FLAGS_W-1:0]    flags_q;
  logic                  pop_ok_q;
  logic [DEPTH_LOG2:0]   sp_q, sp_inc, sp_dec;

  logic                  ram_we, ram_re;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [DATA_W-1:0]     ram_rdata;

  assign sp          = sp_q;
  assign sp_inc      = sp_q + (DEPTH_LOG2+1)'(1);
  assign sp_dec      = sp_q - (DEPTH_LOG2+1)'(1);
  assign stack_full  = (sp_q == (DEPTH_LOG2+1)'(DEPTH));
  assign stack_empty = (sp_q == '0);

  stack_ram #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata ({flags_q, pc_q}),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d      = state_q;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_addr     = sp_q[DEPTH_LOG2-1:0];
    stack_op_end = 1'b0;
    case (state_q)
      ST_IDLE: if (stack_op_ongoing) state_d = ST_ACCESS;
      ST_ACCESS: begin
        state_d = ST_DONE;
        if (op_q == OP_PUSH) begin
          // gated by rst so a reset landing on the access edge aborts the write
          ram_we = !stack_full && !rst;
        end else begin
          ram_re   = !stack_empty;
          ram_addr = sp_dec[DEPTH_LOG2-1:0];
        end
      end
      ST_DONE: begin
        stack_op_end = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sp_q        <= '0;
      return_addr <= '0;
      flags_dout  <= '0;
      stack_ovf   <= 1'b0;
      stack_unf   <= 1'b0;
      pop_ok_q    <= 1'b0;
      op_q        <= OP_POP;
      pc_q        <= '0;
      flags_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (stack_op_ongoing) begin
          op_q    <= push_or_pop;
          pc_q    <= pc;
          flags_q <= flags_din;
        end
        ST_ACCESS: begin
          pop_ok_q <= 1'b0;
          if (op_q == OP_PUSH) begin
            if (stack_full) stack_ovf <= 1'b1;
            else            sp_q      <= sp_inc;
          end else begin
            if (stack_empty) stack_unf <= 1'b1;
            else begin
              sp_q     <= sp_dec;
              pop_ok_q <= 1'b1;
            end
          end
        end
        ST_DONE: if (pop_ok_q) begin
          return_addr <= ram_rdata[PC_W-1:0];
          flags_dout  <= ram_rdata[PC_W +: FLAGS_W];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: a queue-based LIFO model predicts outputs
// at stimulus time; predictions are popped and compared after each operation.
module tb_stack_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       stack_op_ongoing;
  logic       push_or_pop;
  logic [7:0] pc;
  logic [5:0] flags_din;
  logic [7:0] return_addr;
  logic [5:0] flags_dout;
  logic       stack_op_end;
  logic [4:0] sp;
  logic       stack_full, stack_empty, stack_ovf, stack_unf;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] ra;
    logic [5:0] fl;
    int         sp;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t        sb[$];
  logic [13:0] model[$];
  logic [7:0]  m_ra;
  logic [5:0]  m_fl;
  logic        m_ovf, m_unf;

  always #5 clk = ~clk;

  stack_unit #(
    .DEPTH_LOG2 (4),
    .PC_W       (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stack_op_ongoing (stack_op_ongoing),
    .push_or_pop      (push_or_pop),
    .pc               (pc),
    .flags_din        (flags_din),
    .return_addr      (return_addr),
    .flags_dout       (flags_dout),
    .stack_op_end     (stack_op_end),
    .sp               (sp),
    .stack_full       (stack_full),
    .stack_empty      (stack_empty),
    .stack_ovf        (stack_ovf),
    .stack_unf        (stack_unf)
  );

  task automatic model_reset();
    model.delete();
    sb.delete();
    m_ra = '0; m_fl = '0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic model_apply(input logic push, input logic [7:0] p, input logic [5:0] f);
    exp_t e;
    if (push) begin
      if (model.size() < 16) model.push_back({f, p});
      else m_ovf = 1'b1;
    end else begin
      if (model.size() > 0) begin
        logic [13:0] w;
        w = model.pop_back();
        m_ra = w[7:0];
        m_fl = w[13:8];
      end else m_unf = 1'b1;
    end
    e.ra = m_ra; e.fl = m_fl; e.sp = model.size(); e.ovf = m_ovf; e.unf = m_unf;
    sb.push_back(e);
  endtask

  // Drives one request; hold=1 keeps ongoing high one extra cycle (faulty master).
  task automatic do_op(input string tag, input logic push, input logic [7:0] p,
                       input logic [5:0] f, input bit hold);
    exp_t e;
    @(negedge clk);
    stack_op_ongoing = 1'b1; push_or_pop = push; pc = p; flags_din = f;
    model_apply(push, p, f);
    @(negedge clk);
    vectors++;
    if (stack_op_end !== 1'b0) begin
      miscompares++; $display("FAIL %s end_early: got %b want 0", tag, stack_op_end);
    end
    @(negedge clk);
    vectors++;
    if (stack_op_end !== 1'b1) begin
      miscompares++; $display("FAIL %s end_pulse: got %b want 1", tag, stack_op_end);
    end
    @(negedge clk);
    if (!hold) stack_op_ongoing = 1'b0;
    vectors++;
    if (stack_op_end !== 1'b0) begin
      miscompares++; $display("FAIL %s end_width: got %b want 0", tag, stack_op_end);
    end
    e = sb.pop_front();
    vectors++;
    if (return_addr !== e.ra || flags_dout !== e.fl) begin
      miscompares++;
      $display("FAIL %s data: got ra=%h fl=%b want ra=%h fl=%b", tag, return_addr, flags_dout, e.ra, e.fl);
    end
    vectors++;
    if (sp !== 5'(e.sp) || stack_full !== (e.sp == 16) || stack_empty !== (e.sp == 0)) begin
      miscompares++;
      $display("FAIL %s sp: got sp=%0d full=%b empty=%b want sp=%0d", tag, sp, stack_full, stack_empty, e.sp);
    end
    vectors++;
    if (stack_ovf !== e.ovf || stack_unf !== e.unf) begin
      miscompares++;
      $display("FAIL %s sticky: got ovf=%b unf=%b want ovf=%b unf=%b", tag, stack_ovf, stack_unf, e.ovf, e.unf);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; stack_op_ongoing = 1'b0; push_or_pop = 1'b0; pc = '0; flags_din = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    vectors++;
    if ({return_addr, flags_dout, stack_op_end, sp, stack_full, stack_empty, stack_ovf, stack_unf}
        !== {8'h00, 6'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got ra=%h fl=%b end=%b sp=%0d full=%b empty=%b ovf=%b unf=%b want 00/0/0/0/0/1/0/0",
               return_addr, flags_dout, stack_op_end, sp, stack_full, stack_empty, stack_ovf, stack_unf);
    end
  endtask

  task automatic test_push_pop();
    do_op("push_12", 1'b1, 8'h12, 6'b100001, 1'b0);
    do_op("pop_12", 1'b0, 8'h00, 6'b000000, 1'b0);
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 16; i++)
      do_op("fill", 1'b1, 8'(i), 6'(i) ^ 6'h2A, 1'b0);
    do_op("push_ovf", 1'b1, 8'hAA, 6'b111111, 1'b0);
    for (int i = 0; i < 16; i++)
      do_op("drain", 1'b0, 8'h00, 6'b0, 1'b0);
  endtask

  task automatic test_underflow();
    do_op("pop_empty", 1'b0, 8'hFF, 6'b0, 1'b0);
  endtask

  task automatic test_reset_mid_op();
    int ends = 0;
    @(negedge clk);
    stack_op_ongoing = 1'b1; push_or_pop = 1'b1; pc = 8'h55; flags_din = 6'b010101;
    @(negedge clk);
    rst = 1'b1; stack_op_ongoing = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (stack_op_end === 1'b1) ends++;
    end
    vectors++;
    if (ends != 0) begin
      miscompares++; $display("FAIL rst_abort_end: got %0d pulses want 0", ends);
    end
    vectors++;
    if (sp !== 5'd0 || stack_ovf !== 1'b0 || stack_unf !== 1'b0 || return_addr !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_abort_state: got sp=%0d ovf=%b unf=%b ra=%h want 0/0/0/00", sp, stack_ovf, stack_unf, return_addr);
    end
    do_op("pop_after_rst", 1'b0, 8'h00, 6'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   ends = 0;
    // Faulty master: ongoing still high when the FSM returns to IDLE.
    do_op("faulty_first", 1'b1, 8'h77, 6'b000111, 1'b1);
    model_apply(1'b1, 8'h77, 6'b000111);
    @(negedge clk);
    stack_op_ongoing = 1'b0;
    @(negedge clk);
    vectors++;
    if (stack_op_end !== 1'b1) begin
      miscompares++; $display("FAIL faulty_second_end: got %b want 1", stack_op_end);
    end
    @(negedge clk);
    e = sb.pop_front();
    vectors++;
    if (sp !== 5'(e.sp)) begin
      miscompares++; $display("FAIL faulty_second_sp: got %0d want %0d", sp, e.sp);
    end
    // Well-behaved master: exactly one operation.
    do_op("single", 1'b1, 8'h3C, 6'b110000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (stack_op_end === 1'b1) ends++;
    end
    vectors++;
    if (ends != 0 || sp !== 5'(model.size())) begin
      miscompares++; $display("FAIL single_op: got pulses=%0d sp=%0d want 0 and %0d", ends, sp, model.size());
    end
    do_op("pop_3c", 1'b0, 8'h00, 6'b0, 1'b0);
    do_op("pop_77", 1'b0, 8'h00, 6'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_fill_overflow();
    test_underflow();
    test_reset_mid_op();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
